axi_lite_sram_slave: RTL and testbench
======================================

Name: axi_lite_sram_slave

Overview:
- AXI-lite responder that terminates the read channels (AR/R) and write channels (AW/W/B) driven by the fetch and load/store initiators through the bus arbiter.
- Holds a word-addressed SRAM with byte-strobed writes and a programmable read latency.
- Replaces the behavioural memory model, so the CPU bus is closed entirely in RTL.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 64, data width; strobe width is DATA_W/8.
- DEPTH, 4096, number of DATA_W words; power of two.
- BASE, 32'h8000_0000, byte address of word 0.
- READ_LAT, 2, cycles from AR handshake edge to rvalid rising; ≥1.

Ports:
- clk input 1 system clock.
- rst input 1 reset, asynchronous, active-low.
- araddr input ADDR_W read address.
- arvalid input 1 read address valid.
- arready output 1 read address ready.
- rdata output DATA_W read data.
- rresp output 2 read response.
- rvalid output 1 read data valid.
- rready input 1 read data ready.
- awaddr input ADDR_W write address.
- awvalid input 1 write address valid.
- awready output 1 write address ready.
- wdata input DATA_W write data.
- wstrb input DATA_W/8 byte strobes.
- wvalid input 1 write data valid.
- wready output 1 write data ready.
- bresp output 2 write response.
- bvalid output 1 write response valid.
- bready input 1 write response ready.

Behaviour:
- Reset, while rst=0: read FSM goes to R_IDLE; write FSM goes to W_IDLE; held flags clear.
- Reset output values: arready=1, awready=1, wready=1, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0.
- SRAM contents are not reset.
- Reset asserted mid-transaction aborts it. A write not yet committed is dropped.
- Handshake rule: a channel transfers on a clk edge where valid&&ready. Once asserted, rvalid/bvalid hold, with data and resp stable, until the matching ready is seen.
- Word index: (addr-BASE)>>3, keeping log2(DEPTH) bits. addr[2:0] is ignored.
- In range: BASE ≤ addr < BASE+DEPTH*8.
- Read FSM states are R_IDLE, R_WAIT and R_RESP.
  - R_IDLE: arready=1. On AR handshake, latch the index, load cnt=READ_LAT-1 and go to R_WAIT.
  - R_WAIT: arready=0. If cnt==0, sample the SRAM into rdata, set rresp=OKAY (2'b00), set rvalid=1 and go to R_RESP. Otherwise cnt--.
  - R_RESP: on rready, rvalid=0 and go to R_IDLE. arready rises the cycle after the R handshake; a new AR is never accepted in the same cycle.
  - Result: rvalid rises exactly READ_LAT edges after the AR handshake edge.
- Write FSM states are W_IDLE and W_RESP.
  - W_IDLE: awready=!aw_held and wready=!w_held. AW and W are captured independently, in either order or in the same cycle.
  - W_IDLE, first edge with both held: write bytes i where wstrb[i]=1, set bresp=OKAY, set bvalid=1, clear the held flags and go to W_RESP. So with simultaneous AW and W handshakes on edge E0, the commit and bvalid both occur on E1.
  - W_RESP: awready=0 and wready=0. On bready, go to W_IDLE.
- Read/write hazard on the same word: if a read samples on the same edge a write commits, the read returns the pre-write data. A read sampling on any later edge returns the new data.
- Read and write FSMs are fully independent; both may be active in the same cycle.
- wstrb=0 commits nothing but still returns OKAY.
- cnt width is clog2(READ_LAT)+1.

Optional Feature:
- Macro: AXI_SRAM_SLAVE_DECERR_EN.
- Defined: an out-of-range address returns SLVERR (2'b10). An out-of-range read returns rdata=0. An out-of-range write leaves the SRAM unchanged. Latency and handshake timing are identical to the in-range case.
- Undefined: out-of-range addresses alias by truncating the index, and the response is always OKAY.

Decomposition:
- Shared package axi_lite_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, the R_IDLE/R_WAIT/R_RESP and W_IDLE/W_RESP state encodings, and default ADDR_W/DATA_W.
- One sub-module, sram_bank: DEPTH×DATA_W array with a byte-enable write port and a read port registered on a sample strobe.
- axi_lite_sram_slave holds only the FSMs, counter and decode.

Test Plan:
- Write/read: AW=0x8000_0010, W=64'h1122_3344_5566_7788, wstrb=8'hFF, bready=1 → bvalid 1 cycle after handshake with bresp=0. Then AR=0x8000_0010 with READ_LAT=2 → rvalid exactly 2 edges after the AR handshake, with rdata=64'h1122_3344_5566_7788.
- Partial strobe: over the word above, W=64'hAAAA_AAAA_AAAA_AAAA with wstrb=8'h0F → read gives 64'h1122_3344_AAAA_AAAA.
- W-before-AW: wvalid 3 cycles ahead of awvalid → wready drops after the W capture; bvalid rises 1 edge after the AW handshake; data is committed correctly.
- Backpressure: rready=0 for 5 cycles → rvalid, rdata and rresp stay stable, arready stays 0; rready=1 → arready=1 on the next cycle.
- Out-of-range AR=0x7FFF_FFF8:
  - Macro defined → rresp=2'b10, rdata=0.
  - Macro undefined → rresp=0, aliased word data returned.
- Reset mid-read: assert rst=0 while in R_WAIT → rvalid=0 and arready=1 immediately. After release, a fresh read completes normally.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI-lite definitions: response codes, FSM state encodings, default widths.
package axi_lite_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 64;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } r_state_e;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } w_state_e;

endpackage

// File: rtl/axi_lite_sram_slave_sram_bank.sv
// Word-addressed SRAM bank: byte-enable write port, read port registered on a sample strobe.
module sram_bank #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned IDX_W  = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [IDX_W-1:0]    widx,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                rd_en,
  input  logic                rd_zero,
  input  logic [IDX_W-1:0]    ridx,
  output logic [DATA_W-1:0]   rdata
);

  localparam int unsigned STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-strobed write; array contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) mem[widx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Read register; a same-edge write is not visible (returns pre-write data).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= rd_zero ? '0 : mem[ridx];
    end
  end

endmodule

// File: rtl/axi_lite_sram_slave.sv
// AXI-lite SRAM responder: independent read/write FSMs, latency counter, address decode.
// Optional: define AXI_SRAM_SLAVE_DECERR_EN to return SLVERR for out-of-range addresses.
module axi_lite_sram_slave
  import axi_lite_pkg::*;
#(
  parameter int unsigned       ADDR_W   = AXI_ADDR_W,
  parameter int unsigned       DATA_W   = AXI_DATA_W,
  parameter int unsigned       DEPTH    = 4096,
  parameter logic [ADDR_W-1:0] BASE     = ADDR_W'(32'h8000_0000),
  parameter int unsigned       READ_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic                arvalid,
  output logic                arready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rvalid,
  input  logic                rready,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(READ_LAT) + 1;

  logic [IDX_W-1:0] ar_idx_c, aw_idx_c;
  logic             ar_err_c, aw_err_c;

  // Word index is the byte offset from BASE, truncated to the array size.
  assign ar_idx_c = IDX_W'((araddr - BASE) >> 3);
  assign aw_idx_c = IDX_W'((awaddr - BASE) >> 3);

`ifdef AXI_SRAM_SLAVE_DECERR_EN
  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(DEPTH * 8);
  assign ar_err_c = (araddr < BASE) || ((araddr - BASE) >= SPAN);
  assign aw_err_c = (awaddr < BASE) || ((awaddr - BASE) >= SPAN);
`else
  assign ar_err_c = 1'b0;
  assign aw_err_c = 1'b0;
`endif

  // ---------------- read channel ----------------
  r_state_e         r_state, r_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [IDX_W-1:0] r_idx, r_idx_next;
  logic             r_err, r_err_next;
  logic             rvalid_next, arready_next, rd_sample_c;
  logic [1:0]       rresp_next;

  // Read FSM state and registered read-side outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= R_IDLE;
      cnt     <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
      rvalid  <= 1'b0;
      rresp   <= RESP_OKAY;
      arready <= 1'b1;
    end else begin
      r_state <= r_next;
      cnt     <= cnt_next;
      r_idx   <= r_idx_next;
      r_err   <= r_err_next;
      rvalid  <= rvalid_next;
      rresp   <= rresp_next;
      arready <= arready_next;
    end
  end

  // Read next-state: accept AR, count down the latency, hold R until rready.
  always_comb begin
    r_next      = r_state;
    cnt_next    = cnt;
    r_idx_next  = r_idx;
    r_err_next  = r_err;
    rvalid_next = rvalid;
    rresp_next  = rresp;
    rd_sample_c = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (arvalid && arready) begin
          r_idx_next = ar_idx_c;
          r_err_next = ar_err_c;
          cnt_next   = CNT_W'(READ_LAT - 1);
          r_next     = R_WAIT;
        end
      end
      R_WAIT: begin
        if (cnt == '0) begin
          rd_sample_c = 1'b1;
          rresp_next  = r_err ? RESP_SLVERR : RESP_OKAY;
          rvalid_next = 1'b1;
          r_next      = R_RESP;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      R_RESP: begin
        if (rready) begin
          rvalid_next = 1'b0;
          r_next      = R_IDLE;
        end
      end
      default: r_next = R_IDLE;
    endcase
    arready_next = (r_next == R_IDLE);
  end

  // ---------------- write channel ----------------
  w_state_e          w_state, w_next;
  logic              aw_held, aw_held_next, w_held, w_held_next;
  logic [IDX_W-1:0]  w_idx, w_idx_next;
  logic              w_err, w_err_next;
  logic [DATA_W-1:0] w_data, w_data_next;
  logic [STRB_W-1:0] w_strb, w_strb_next;
  logic              bvalid_next, awready_next, wready_next, commit_c;
  logic [1:0]        bresp_next;

  // Write FSM state, held AW/W payloads and registered write-side outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state <= W_IDLE;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      w_idx   <= '0;
      w_err   <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      awready <= 1'b1;
      wready  <= 1'b1;
    end else begin
      w_state <= w_next;
      aw_held <= aw_held_next;
      w_held  <= w_held_next;
      w_idx   <= w_idx_next;
      w_err   <= w_err_next;
      w_data  <= w_data_next;
      w_strb  <= w_strb_next;
      bvalid  <= bvalid_next;
      bresp   <= bresp_next;
      awready <= awready_next;
      wready  <= wready_next;
    end
  end

  // Write next-state: capture AW and W independently, commit once both are held.
  always_comb begin
    w_next       = w_state;
    aw_held_next = aw_held;
    w_held_next  = w_held;
    w_idx_next   = w_idx;
    w_err_next   = w_err;
    w_data_next  = w_data;
    w_strb_next  = w_strb;
    bvalid_next  = bvalid;
    bresp_next   = bresp;
    commit_c     = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (aw_held && w_held) begin
          commit_c     = 1'b1;
          bresp_next   = w_err ? RESP_SLVERR : RESP_OKAY;
          bvalid_next  = 1'b1;
          aw_held_next = 1'b0;
          w_held_next  = 1'b0;
          w_next       = W_RESP;
        end else begin
          if (awvalid && awready) begin
            aw_held_next = 1'b1;
            w_idx_next   = aw_idx_c;
            w_err_next   = aw_err_c;
          end
          if (wvalid && wready) begin
            w_held_next = 1'b1;
            w_data_next = wdata;
            w_strb_next = wstrb;
          end
        end
      end
      W_RESP: begin
        if (bready) begin
          bvalid_next = 1'b0;
          w_next      = W_IDLE;
        end
      end
    endcase
    awready_next = (w_next == W_IDLE) && !aw_held_next;
    wready_next  = (w_next == W_IDLE) && !w_held_next;
  end

  sram_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .we      (commit_c && !w_err),
    .widx    (w_idx),
    .wdata   (w_data),
    .wstrb   (w_strb),
    .rd_en   (rd_sample_c),
    .rd_zero (r_err),
    .ridx    (r_idx),
    .rdata   (rdata)
  );

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Scoreboard bench for axi_lite_sram_slave; honours AXI_SRAM_SLAVE_DECERR_EN when defined.
module tb_axi_lite_sram_slave;

  localparam int unsigned READ_LAT = 2;
  localparam logic [31:0] BASE     = 32'h8000_0000;
`ifdef AXI_SRAM_SLAVE_DECERR_EN
  localparam bit DECERR = 1'b1;
`else
  localparam bit DECERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr, awaddr;
  logic        arvalid, arready, rvalid, rready;
  logic [63:0] rdata, wdata;
  logic [1:0]  rresp, bresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [7:0]  wstrb;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          aw_hs_cyc, w_hs_cyc;
  logic [65:0] rq[$];
  logic [1:0]  bq[$];
  logic [63:0] model [0:4095];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_lite_sram_slave #(.READ_LAT(READ_LAT)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic in_rng(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a >= BASE) && (off < 32'h0000_8000);
  endfunction

  function automatic logic [11:0] idx_of(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) >> 3;
    return off[11:0];
  endfunction

  function automatic logic [65:0] exp_read(input logic [31:0] a);
    if (DECERR && !in_rng(a)) return {2'b10, 64'h0};
    return {2'b00, model[idx_of(a)]};
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    logic [11:0] i;
    logic [63:0] w;
    if (DECERR && !in_rng(a)) begin
      bq.push_back(2'b10);
      return;
    end
    bq.push_back(2'b00);
    i = idx_of(a);
    w = model[i];
    for (int b = 0; b < 8; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
    model[i] = w;
  endtask

  task automatic aw_chan(input logic [31:0] a, input int lead);
    logic seen;
    int   n;
    repeat (lead) begin @(posedge clk); #1; end
    awaddr = a; awvalid = 1'b1; seen = 1'b0; n = 0;
    while (!seen && n < 50) begin
      @(negedge clk); seen = awready;
      @(posedge clk); #1; n++;
    end
    awvalid = 1'b0;
    aw_hs_cyc = cyc;
    check_eq("aw_handshake", 64'(seen), 64'd1);
    check_eq("aw_ready_drop", 64'(awready), 64'd0);
  endtask

  task automatic w_chan(input logic [63:0] d, input logic [7:0] s, input int lead);
    logic seen;
    int   n;
    repeat (lead) begin @(posedge clk); #1; end
    wdata = d; wstrb = s; wvalid = 1'b1; seen = 1'b0; n = 0;
    while (!seen && n < 50) begin
      @(negedge clk); seen = wready;
      @(posedge clk); #1; n++;
    end
    wvalid = 1'b0;
    w_hs_cyc = cyc;
    check_eq("w_handshake", 64'(seen), 64'd1);
    check_eq("w_ready_drop", 64'(wready), 64'd0);
  endtask

  // Expectations are pushed at drive time; bresp is popped when B appears.
  task automatic axi_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                           input int w_lead, input int aw_lead);
    int n;
    logic [1:0] exp;
    model_write(a, d, s);
    fork
      w_chan(d, s, w_lead);
      aw_chan(a, aw_lead);
    join
    n = 0;
    while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
    check_eq("b_latency", 64'(n), 64'd1);
    exp = bq.pop_front();
    check_eq("b_resp", 64'(bresp), 64'(exp));
    @(posedge clk); #1;
    check_eq("b_done", 64'(bvalid), 64'd0);
  endtask

  task automatic axi_read(input logic [31:0] a, input int hold);
    logic        seen;
    int          n;
    logic [65:0] exp;
    logic [63:0] d0;
    logic [1:0]  r0;
    exp = exp_read(a);
    rq.push_back(exp);
    araddr = a; arvalid = 1'b1; seen = 1'b0; n = 0;
    while (!seen && n < 50) begin
      @(negedge clk); seen = arready;
      @(posedge clk); #1; n++;
    end
    arvalid = 1'b0;
    check_eq("ar_handshake", 64'(seen), 64'd1);
    check_eq("ar_ready_drop", 64'(arready), 64'd0);
    n = 0;
    while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
    check_eq("r_latency", 64'(n), 64'(READ_LAT));
    d0 = rdata; r0 = rresp;
    repeat (hold) begin
      @(posedge clk); #1;
      check_eq("r_hold_valid", 64'(rvalid), 64'd1);
      check_eq("r_hold_data", rdata, exp[63:0]);
      check_eq("r_hold_resp", 64'(rresp), 64'(exp[65:64]));
      check_eq("r_hold_arready", 64'(arready), 64'd0);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check_eq("r_done_valid", 64'(rvalid), 64'd0);
    check_eq("r_done_arready", 64'(arready), 64'd1);
    exp = rq.pop_front();
    check_eq("r_data", d0, exp[63:0]);
    check_eq("r_resp", 64'(r0), 64'(exp[65:64]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, miscompares %0d", miscompares);
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b1;
    #12;
    check_eq("rst_arready", 64'(arready), 64'd1);
    check_eq("rst_awready", 64'(awready), 64'd1);
    check_eq("rst_wready", 64'(wready), 64'd1);
    check_eq("rst_rvalid", 64'(rvalid), 64'd0);
    check_eq("rst_bvalid", 64'(bvalid), 64'd0);
    check_eq("rst_rdata", rdata, 64'd0);
    check_eq("rst_rresp", 64'(rresp), 64'd0);
    check_eq("rst_bresp", 64'(bresp), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Full write then read back; partial strobe over the same word.
    axi_write(32'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 0, 0);
    axi_read(32'h8000_0010, 0);
    axi_write(32'h8000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 0, 0);
    axi_read(32'h8000_0010, 0);

    // W leads AW by three cycles.
    axi_write(32'h8000_0020, 64'hDEAD_BEEF_0123_4567, 8'hFF, 0, 3);
    axi_read(32'h8000_0020, 0);

    // R backpressure.
    axi_read(32'h8000_0010, 5);

    // Zero strobe: no change, still OKAY.
    axi_write(32'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0, 0);
    axi_read(32'h8000_0010, 0);

    // Range boundaries: first/last word and both neighbours outside.
    axi_write(32'h8000_0000, 64'h0102_0304_0506_0708, 8'hFF, 0, 0);
    axi_write(32'h8000_7FF8, 64'h0BAD_F00D_CAFE_BABE, 8'hFF, 0, 0);
    axi_read(32'h8000_7FF8, 0);
    axi_read(32'h7FFF_FFF8, 0);
    axi_read(32'h8000_8000, 0);

    // Read sampling on the commit edge sees old data; a later read sees new.
    fork
      axi_read(32'h8000_0020, 0);
      begin
        @(posedge clk); #1;
        axi_write(32'h8000_0020, 64'h5555_6666_7777_8888, 8'hFF, 0, 0);
      end
    join
    axi_read(32'h8000_0020, 0);

    // Reset while in R_WAIT aborts the read.
    araddr = 32'h8000_0010; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    check_eq("rstmid_rvalid", 64'(rvalid), 64'd0);
    check_eq("rstmid_arready", 64'(arready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    axi_read(32'h8000_0020, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
